// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war game blocks.
package tug_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      RELEASE = 2'd2
   } cpu_state_t;

   localparam int         LFSR_W_DEF      = 10;
   localparam logic [9:0] LFSR_SEED       = 10'h001;
   // x^10 + x^7 + 1, expressed as bit positions of the left-shifting register
   localparam int         LFSR_TAP_HI     = 9;
   localparam int         LFSR_TAP_LO     = 6;
   localparam int         TICK_DIV_DEF    = 1024;
   localparam int         HOLD_CYCLES_DEF = 2;

endpackage

// File: rtl/cpu_lfsr.sv
// Fibonacci left-shift LFSR with advance strobe and all-zero lockup recovery.
module cpu_lfsr
   import tug_pkg::*;
#(
   parameter int           W    = LFSR_W_DEF,
   parameter logic [W-1:0] SEED = W'(LFSR_SEED)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         advance,
   output logic [W-1:0] value
);

   logic [W-1:0] lfsr_reg;
   logic [W-1:0] lfsr_next;

   always_comb begin
      lfsr_next = lfsr_reg;
      // The zero state would otherwise lock up forever, so it wins over advance
      if (lfsr_reg == '0)
         lfsr_next = SEED;
      else if (advance)
         lfsr_next = {lfsr_reg[W-2:0], lfsr_reg[LFSR_TAP_HI] ^ lfsr_reg[LFSR_TAP_LO]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lfsr_reg <= SEED;
      else
         lfsr_reg <= lfsr_next;
   end

   assign value = lfsr_reg;

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: emulates an active-low push-button at an LFSR-driven rate.
// Define CPU_SYNC_EN to pass enable/difficulty through two-flop synchronizers.
module cpu_player
   import tug_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int LFSR_W      = LFSR_W_DEF,
   parameter int DIFF_W      = LFSR_W - 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DIFF_W-1:0] difficulty,
   output logic              key_n,
   output logic [7:0]        press_count
);

   localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   if (TICK_DIV <= 2 * HOLD_CYCLES) begin : g_bad_cfg
      $error("cpu_player: TICK_DIV must exceed 2*HOLD_CYCLES");
   end

   logic              en_use;
   logic [DIFF_W-1:0] diff_use;

`ifdef CPU_SYNC_EN
   logic [1:0]        en_sync_reg;
   logic [DIFF_W-1:0] diff_sync1_reg;
   logic [DIFF_W-1:0] diff_sync2_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_sync_reg    <= '0;
         diff_sync1_reg <= '0;
         diff_sync2_reg <= '0;
      end else begin
         en_sync_reg    <= {en_sync_reg[0], enable};
         diff_sync1_reg <= difficulty;
         diff_sync2_reg <= diff_sync1_reg;
      end
   end

   assign en_use   = en_sync_reg[1];
   assign diff_use = diff_sync2_reg;
`else
   assign en_use   = enable;
   assign diff_use = difficulty;
`endif

   logic [CNT_W-1:0] cnt_reg;
   logic             tick;

   // Gated by enable so the cycle in which enable drops cannot still fire a tick
   assign tick = en_use && (cnt_reg == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_reg <= '0;
      else if (!en_use || tick)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 1'b1;
   end

   logic [LFSR_W-1:0] lfsr_value;
   logic              press_hit;

   cpu_lfsr #(
      .W    (LFSR_W),
      .SEED (LFSR_W'(LFSR_SEED))
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (tick),
      .value   (lfsr_value)
   );

   assign press_hit = lfsr_value < {diff_use, 1'b0};

   cpu_state_t       state_reg, state_next;
   logic [HOLD_W-1:0] hold_reg, hold_next;
   logic             key_n_reg, key_n_next;
   logic [7:0]       count_reg, count_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         hold_reg  <= '0;
         key_n_reg <= 1'b1;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         key_n_reg <= key_n_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      key_n_next = key_n_reg;
      count_next = count_reg;
      if (!en_use) begin
         state_next = IDLE;
         hold_next  = '0;
         key_n_next = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               hold_next = '0;
               if (tick && press_hit) begin
                  state_next = PRESS;
                  key_n_next = 1'b0;
                  if (count_reg != 8'hFF)
                     count_next = count_reg + 8'd1;
               end
            end
            PRESS: begin
               if (hold_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                  state_next = RELEASE;
                  hold_next  = '0;
                  key_n_next = 1'b1;
               end else begin
                  hold_next = hold_reg + 1'b1;
               end
            end
            RELEASE: begin
               if (hold_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                  state_next = IDLE;
                  hold_next  = '0;
               end else begin
                  hold_next = hold_reg + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               hold_next  = '0;
               key_n_next = 1'b1;
            end
         endcase
      end
   end

   assign key_n       = key_n_reg;
   assign press_count = count_reg;

endmodule

// File: tb/tb_cpu_player.sv
// Directed self-checking bench for cpu_player with TICK_DIV=4, HOLD_CYCLES=2.
module tb_cpu_player;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [8:0] difficulty = '0;
   logic       key_n;
   logic [7:0] press_count;

   int n_checks = 0;
   int n_fails  = 0;

   cpu_player #(
      .TICK_DIV    (4),
      .HOLD_CYCLES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .difficulty  (difficulty),
      .key_n       (key_n),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Leaves the bench at a negedge with reset low: the current cycle is cycle 0
   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   int lows;
   int low_len, high_len, bad_low, bad_gap, npulses;
   logic prev;

   initial begin
      // Reset state
      enable = 1'b1;
      difficulty = 9'd0;
      do_reset();
      check("rst_key_n", 32'(key_n), 32'd1);
      check("rst_count", 32'(press_count), 32'd0);
      check("rst_lfsr", 32'(dut.u_lfsr.lfsr_reg), 32'h001);
      check("rst_state", 32'(dut.state_reg), 32'd0);

      // Difficulty 0 never presses
      lows = 0;
      for (int c = 0; c < 200; c++) begin
         if (key_n == 1'b0) lows++;
         step(1);
      end
      check("d0_low_cycles", 32'(lows), 32'd0);
      check("d0_count", 32'(press_count), 32'd0);

      // Difficulty 1: only lfsr==1 presses, i.e. the first tick at cycle 3
      difficulty = 9'd1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         check($sformatf("d1_key_n_c%0d", c), 32'(key_n), (c == 4 || c == 5) ? 32'd0 : 32'd1);
         step(1);
      end
      check("d1_count", 32'(press_count), 32'd1);
      step(10);
      check("d1_count_later", 32'(press_count), 32'd1);

      // Drop enable mid-press, then re-enable
      difficulty = 9'h1FF;
      do_reset();
      step(4);
      check("en_press_seen", 32'(key_n), 32'd0);
      check("en_lfsr_pre", 32'(dut.u_lfsr.lfsr_reg), 32'd2);
      enable = 1'b0;
      step(1);
      check("en_off_key_n", 32'(key_n), 32'd1);
      check("en_off_state", 32'(dut.state_reg), 32'd0);
      step(3);
      check("en_off_lfsr", 32'(dut.u_lfsr.lfsr_reg), 32'd2);
      check("en_off_count", 32'(press_count), 32'd1);
      enable = 1'b1;
      step(3);
      check("reen_c3_key_n", 32'(key_n), 32'd1);
      step(1);
      check("reen_c4_key_n", 32'(key_n), 32'd0);
      check("reen_count", 32'(press_count), 32'd2);
      check("reen_lfsr", 32'(dut.u_lfsr.lfsr_reg), 32'd4);

      // Asynchronous reset while key_n is low
      reset = 1'b1;
      #1;
      check("arst_key_n", 32'(key_n), 32'd1);
      check("arst_count", 32'(press_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("arst_lfsr", 32'(dut.u_lfsr.lfsr_reg), 32'h001);

      // Max difficulty for 4000 cycles: pulse shape and saturation
      do_reset();
      prev = 1'b1;
      low_len = 0; high_len = 0; bad_low = 0; bad_gap = 0; npulses = 0;
      for (int c = 0; c < 4000; c++) begin
         if (key_n == 1'b0) begin
            if (prev == 1'b1) begin
               if (npulses > 0 && high_len < 2) bad_gap++;
               high_len = 0;
            end
            low_len++;
         end else begin
            if (prev == 1'b0) begin
               if (low_len != 2) bad_low++;
               npulses++;
               low_len = 0;
            end
            high_len++;
         end
         prev = key_n;
         step(1);
      end
      check("sat_bad_widths", 32'(bad_low), 32'd0);
      check("sat_bad_gaps", 32'(bad_gap), 32'd0);
      check("sat_enough_pulses", 32'(npulses >= 255), 32'd1);
      check("sat_count", 32'(press_count), 32'd255);

      // Zero-lockup recovery while frozen
      enable = 1'b0;
      step(1);
      dut.u_lfsr.lfsr_reg = '0;
      step(1);
      check("zero_reload", 32'(dut.u_lfsr.lfsr_reg), 32'h001);
      check("frozen_count", 32'(press_count), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cpu_player.md
Name: cpu_player

Overview:
- Computer opponent for the tug-of-war game. It emulates one human push-button by driving an active-low key line, which feeds the game's per-player key conditioner exactly as a physical KEY would.
- Press rate is set by a 9-bit difficulty value, normally taken from the board switches. Randomness comes from a 10-bit LFSR.
- Sits upstream of the game top level and replaces key[3] in player-vs-computer builds.

Parameters:
- TICK_DIV, 1024: clock cycles between decision ticks (simulation uses 4).
- HOLD_CYCLES, 2: cycles key_n stays low per press; the release gap also lasts this many cycles.
- LFSR_W, 10: LFSR width. DIFF_W is fixed at LFSR_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = CPU plays; 0 = freeze (e.g. round won, victory display showing)
- difficulty  in  9  press threshold; 0 = never presses, larger = more aggressive
- key_n  out  1  emulated push-button, active low (0 = pressed)
- press_count  out  8  saturating count of presses issued since reset (debug / HEX)

Behaviour:
- Reset (async, active-high):
  - key_n=1, press_count=0, state=IDLE
  - tick counter=0, lfsr=10'h001
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where counter==TICK_DIV-1.
  - First tick after reset release falls on cycle TICK_DIV-1.
- LFSR:
  - Fibonacci, left shift. New lsb = lfsr[9]^lfsr[6] (x^10+x^7+1). Advances on the tick edge only.
  - If the value is ever all-zero, reload 10'h001 on the next edge (defensive).
  - Sequence from seed: 1, 2, 4, 8, 16, 32, 64, 129, ...
- Decision:
  - On a tick while in IDLE, press iff lfsr < {difficulty,1'b0}.
  - The comparison uses the pre-advance lfsr value. It is unsigned and LFSR_W bits wide.
- FSM states IDLE, PRESS, RELEASE:
  - IDLE→PRESS on tick && press decision. key_n=0 from the next edge. press_count increments on this transition and saturates at 255.
  - PRESS→RELEASE after HOLD_CYCLES cycles in PRESS. key_n=1 from the next edge.
  - RELEASE→IDLE after HOLD_CYCLES cycles.
  - Ticks arriving in PRESS or RELEASE are ignored for decisions, but the LFSR still advances.
- key_n is registered: no combinational path from any input.
- enable=0:
  - At the next edge: state→IDLE, key_n=1, tick counter→0; LFSR and press_count hold.
  - A press in progress is aborted cleanly (key_n returns high).
  - Re-enable restarts the tick count from 0.
- difficulty changes take effect at the next tick decision.
- Reset mid-press: key_n=1 immediately (asynchronous).
- Constraint: TICK_DIV > 2*HOLD_CYCLES, enforced by an elaboration-time assertion.

Optional Feature:
- Macro CPU_SYNC_EN.
- Defined: difficulty and enable each pass through a two-flop synchronizer (reset value 0) before use. This adds 2 cycles of latency to their effect.
- Undefined: both inputs are used directly, with zero added latency; the caller guarantees they are synchronous to clk.

Decomposition:
- Shared package tug_pkg holds:
  - the cpu_state_t enum (IDLE, PRESS, RELEASE)
  - LFSR_SEED = 10'h001
  - LFSR tap positions
  - the default TICK_DIV and HOLD_CYCLES constants
- One natural sub-module: cpu_lfsr (width parameter, advance strobe, seed reload, zero-lockup guard).
- Tick counter, compare and FSM stay in cpu_player.

Test Plan (TICK_DIV=4, HOLD_CYCLES=2, CPU_SYNC_EN undefined):
- Reset, enable=1, difficulty=0, run 200 cycles → key_n stays 1, press_count=0.
- Reset, enable=1, difficulty=1 → first tick at cycle 3 (lfsr=1 < 2): key_n=0 for cycles 4-5, 1 from cycle 6; press_count=1. Second tick (lfsr=2, not < 2) → no press.
- difficulty=9'h1FF, run 4000 cycles → every key_n low pulse is exactly 2 cycles wide, separated by ≥2 high cycles; press_count saturates at 255.
- Drop enable during a PRESS → key_n=1 at the next edge; lfsr holds. Re-enable → next decision occurs 4 cycles later.
- Assert reset mid-press → key_n=1 without waiting for a clock edge; after release, lfsr=1 and press_count=0.
- Force lfsr to 0 via hierarchical deposit → the value after the next edge is 10'h001.
